// File: rtl/cpu_ctrl_if.sv
// Control-side bundle for cpu_ctrl: run/IR/flag/memory inputs and datapath/memory strobes.
// The illegal strobe exists only when CTRL_TRAP_EN is defined.
interface cpu_ctrl_if;
  logic       run;
  logic [3:0] opcode;
  logic [3:0] imed_reg;
  logic       zero_flag;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       load_ir;
  logic       pc_inc;
  logic       pc_load;
  logic [2:0] alu_op;
  logic       alu_src;
  logic       acc_we;
  logic       busy;
  logic       halted;
`ifdef CTRL_TRAP_EN
  logic       illegal;
`endif

  modport master (
`ifdef CTRL_TRAP_EN
    output illegal,
`endif
    input  run, opcode, imed_reg, zero_flag, mem_ack,
    output mem_req, mem_we, load_ir, pc_inc, pc_load, alu_op, alu_src, acc_we, busy, halted
  );

  modport slave (
`ifdef CTRL_TRAP_EN
    input  illegal,
`endif
    output run, opcode, imed_reg, zero_flag, mem_ack,
    input  mem_req, mem_we, load_ir, pc_inc, pc_load, alu_op, alu_src, acc_we, busy, halted
  );
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle control FSM for the 8-bit core: fetch, decode, execute and memory sequencing.
// Optional CTRL_TRAP_EN builds a TRAP state that catches reserved opcodes C-E.
module cpu_ctrl (
  input logic       clk,
  input logic       rst,
  cpu_ctrl_if.master bus
);

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLdi = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpAnd = 4'h4;
  localparam logic [3:0] OpOr  = 4'h5;
  localparam logic [3:0] OpXor = 4'h6;
  localparam logic [3:0] OpMov = 4'h7;
  localparam logic [3:0] OpLd  = 4'h8;
  localparam logic [3:0] OpSt  = 4'h9;
  localparam logic [3:0] OpJmp = 4'hA;
  localparam logic [3:0] OpJz  = 4'hB;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
`ifdef CTRL_TRAP_EN
    StTrap,
`endif
    StHalt
  } state_e;

  state_e state_q, state_d;

  logic       mem_req, mem_we, load_ir, pc_inc, pc_load;
  logic [2:0] alu_op;
  logic       alu_src, acc_we, busy, halted;
  logic       illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    load_ir = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    alu_op  = 3'd0;
    alu_src = 1'b0;
    acc_we  = 1'b0;
    busy    = 1'b0;
    halted  = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.run) state_d = StFetch;
      end
      StFetch: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          load_ir = 1'b1;
          pc_inc  = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // IR contents only become valid here, so no strobes this cycle.
        busy = 1'b1;
        case (bus.opcode)
          OpHlt:       state_d = StHalt;
          OpLd, OpSt:  state_d = StMem;
`ifdef CTRL_TRAP_EN
          4'hC, 4'hD, 4'hE: state_d = StTrap;
`endif
          default:     state_d = StExec;
        endcase
      end
      StExec: begin
        busy = 1'b1;
        case (bus.opcode)
          OpLdi: begin
            alu_src = 1'b1;
            acc_we  = 1'b1;
          end
          OpMov: acc_we = 1'b1;
          OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
            alu_op = 3'(bus.opcode - 4'd1);
            acc_we = 1'b1;
          end
          OpJmp:   pc_load = 1'b1;
          OpJz:    pc_load = bus.zero_flag;
          default: ;
        endcase
        state_d = bus.run ? StFetch : StIdle;
      end
      StMem: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = (bus.opcode == OpSt);
        if (bus.mem_ack) begin
          acc_we  = (bus.opcode == OpLd);
          state_d = bus.run ? StFetch : StIdle;
        end
      end
      StHalt: begin
        halted = 1'b1;
      end
`ifdef CTRL_TRAP_EN
      StTrap: begin
        halted  = 1'b1;
        illegal = 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign bus.mem_req = mem_req;
  assign bus.mem_we  = mem_we;
  assign bus.load_ir = load_ir;
  assign bus.pc_inc  = pc_inc;
  assign bus.pc_load = pc_load;
  assign bus.alu_op  = alu_op;
  assign bus.alu_src = alu_src;
  assign bus.acc_we  = acc_we;
  assign bus.busy    = busy;
  assign bus.halted  = halted;
`ifdef CTRL_TRAP_EN
  assign bus.illegal = illegal;
`else
  logic unused_illegal;
  assign unused_illegal = illegal ^ ^bus.imed_reg ^ OpNop[0];
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: per-cycle vectors of inputs and expected packed outputs.
// Packed order: {illegal, mem_req, mem_we, load_ir, pc_inc, pc_load, alu_op[2:0], alu_src,
// acc_we, busy, halted}.
module tb_cpu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  cpu_ctrl_if bus ();

  cpu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        run;
    logic        ack;
    logic        zf;
    logic [7:0]  ir;
    logic [12:0] exp;
  } vec_t;

  localparam logic [12:0] XIdle  = 13'h0000;
  localparam logic [12:0] XWait  = 13'h0802;
  localparam logic [12:0] XFAck  = 13'h0B02;
  localparam logic [12:0] XBusy  = 13'h0002;
  localparam logic [12:0] XHalt  = 13'h0001;
  localparam logic [12:0] XTrap  = 13'h1001;

  function automatic vec_t mk(input logic r, input logic run, input logic ack, input logic zf,
                              input logic [7:0] ir, input logic [12:0] exp);
    vec_t v;
    v.rst = r; v.run = run; v.ack = ack; v.zf = zf; v.ir = ir; v.exp = exp;
    return v;
  endfunction

  function automatic logic [12:0] obs();
    logic ill;
`ifdef CTRL_TRAP_EN
    ill = bus.illegal;
`else
    ill = 1'b0;
`endif
    return {ill, bus.mem_req, bus.mem_we, bus.load_ir, bus.pc_inc, bus.pc_load, bus.alu_op,
            bus.alu_src, bus.acc_we, bus.busy, bus.halted};
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    bus.run       = v.run;
    bus.mem_ack   = v.ack;
    bus.zero_flag = v.zf;
    bus.opcode    = v.ir[3:0];
    bus.imed_reg  = v.ir[7:4];
    #1;
  endtask

  task automatic test_reset();
    vec_t q[$];
    q.push_back(mk(1, 1, 1, 0, 8'h51, XIdle));
    q.push_back(mk(0, 0, 1, 0, 8'h51, XIdle));
    q.push_back(mk(0, 0, 0, 0, 8'h51, XIdle));
    foreach (q[i]) begin
      drive(q[i]);
      n_total++;
      if (obs() !== q[i].exp) $display("FAIL reset[%0d]: got %h expected %h", i, obs(), q[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_ldi();
    vec_t q[$];
    q.push_back(mk(0, 1, 0, 0, 8'h51, XIdle));
    q.push_back(mk(0, 1, 1, 0, 8'h51, XFAck));
    q.push_back(mk(0, 1, 0, 0, 8'h51, XBusy));
    q.push_back(mk(0, 1, 0, 0, 8'h51, 13'h000E));
    q.push_back(mk(0, 0, 0, 0, 8'h00, XWait));
    q.push_back(mk(0, 0, 1, 0, 8'h00, XFAck));
    q.push_back(mk(0, 0, 0, 0, 8'h00, XBusy));
    q.push_back(mk(0, 0, 0, 0, 8'h00, XBusy));
    q.push_back(mk(0, 0, 1, 0, 8'h00, XIdle));
    q.push_back(mk(0, 0, 0, 0, 8'h00, XIdle));
    foreach (q[i]) begin
      drive(q[i]);
      n_total++;
      if (obs() !== q[i].exp) $display("FAIL ldi[%0d]: got %h expected %h", i, obs(), q[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_add_wait();
    vec_t q[$];
    q.push_back(mk(0, 1, 0, 0, 8'h02, XIdle));
    q.push_back(mk(0, 1, 0, 0, 8'h02, XWait));
    q.push_back(mk(0, 1, 0, 0, 8'h02, XWait));
    q.push_back(mk(0, 1, 0, 0, 8'h02, XWait));
    q.push_back(mk(0, 1, 1, 0, 8'h02, XFAck));
    q.push_back(mk(0, 1, 1, 0, 8'h02, XBusy));
    q.push_back(mk(0, 0, 1, 0, 8'h02, 13'h0016));
    q.push_back(mk(0, 0, 0, 0, 8'h02, XIdle));
    foreach (q[i]) begin
      drive(q[i]);
      n_total++;
      if (obs() !== q[i].exp) $display("FAIL add_wait[%0d]: got %h expected %h", i, obs(), q[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_jz();
    vec_t q[$];
    q.push_back(mk(0, 1, 0, 0, 8'h3B, XIdle));
    q.push_back(mk(0, 1, 1, 0, 8'h3B, XFAck));
    q.push_back(mk(0, 1, 0, 0, 8'h3B, XBusy));
    q.push_back(mk(0, 1, 0, 0, 8'h3B, XBusy));
    q.push_back(mk(0, 1, 1, 1, 8'h3B, XFAck));
    q.push_back(mk(0, 1, 0, 1, 8'h3B, XBusy));
    q.push_back(mk(0, 0, 0, 1, 8'h3B, 13'h0082));
    q.push_back(mk(0, 0, 0, 1, 8'h3B, XIdle));
    foreach (q[i]) begin
      drive(q[i]);
      n_total++;
      if (obs() !== q[i].exp) $display("FAIL jz[%0d]: got %h expected %h", i, obs(), q[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_st_ld();
    vec_t q[$];
    q.push_back(mk(0, 1, 0, 0, 8'h79, XIdle));
    q.push_back(mk(0, 1, 1, 0, 8'h79, XFAck));
    q.push_back(mk(0, 1, 0, 0, 8'h79, XBusy));
    q.push_back(mk(0, 1, 0, 0, 8'h79, 13'h0C02));
    q.push_back(mk(0, 1, 1, 0, 8'h79, 13'h0C02));
    q.push_back(mk(0, 1, 1, 0, 8'h78, XFAck));
    q.push_back(mk(0, 1, 0, 0, 8'h78, XBusy));
    q.push_back(mk(0, 0, 0, 0, 8'h78, XWait));
    q.push_back(mk(0, 0, 1, 0, 8'h78, 13'h0806));
    q.push_back(mk(0, 0, 0, 0, 8'h78, XIdle));
    foreach (q[i]) begin
      drive(q[i]);
      n_total++;
      if (obs() !== q[i].exp) $display("FAIL st_ld[%0d]: got %h expected %h", i, obs(), q[i].exp);
      else n_pass++;
    end
  endtask

  // SUB, AND, OR, XOR, MOV, JMP, NOP issued with no gaps between instructions.
  task automatic test_back_to_back();
    vec_t        q[$];
    logic [7:0]  ops [7];
    logic [12:0] exs [7];
    ops = '{8'h03, 8'h14, 8'h25, 8'h36, 8'h47, 8'h5A, 8'h00};
    exs = '{13'h0026, 13'h0036, 13'h0046, 13'h0056, 13'h0006, 13'h0082, 13'h0002};
    q.push_back(mk(0, 1, 0, 0, ops[0], XIdle));
    for (int k = 0; k < 7; k++) begin
      q.push_back(mk(0, 1, 1, 0, ops[k], XFAck));
      q.push_back(mk(0, 1, 0, 0, ops[k], XBusy));
      q.push_back(mk(0, (k != 6), 0, 0, ops[k], exs[k]));
    end
    q.push_back(mk(0, 0, 0, 0, 8'h00, XIdle));
    foreach (q[i]) begin
      drive(q[i]);
      n_total++;
      if (obs() !== q[i].exp) $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs(), q[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    vec_t q[$];
    q.push_back(mk(0, 1, 0, 0, 8'h0F, XIdle));
    q.push_back(mk(0, 1, 1, 0, 8'h0F, XFAck));
    q.push_back(mk(0, 0, 0, 0, 8'h0F, XBusy));
    q.push_back(mk(0, 0, 0, 0, 8'h0F, XHalt));
    q.push_back(mk(0, 1, 1, 0, 8'h0F, XHalt));
    q.push_back(mk(0, 0, 0, 0, 8'h0F, XHalt));
    q.push_back(mk(1, 0, 0, 0, 8'h0F, XHalt));
    q.push_back(mk(0, 0, 0, 0, 8'h0F, XIdle));
    q.push_back(mk(0, 1, 0, 0, 8'h02, XIdle));
    q.push_back(mk(0, 1, 0, 0, 8'h02, XWait));
    q.push_back(mk(1, 1, 0, 0, 8'h02, XWait));
    q.push_back(mk(0, 0, 0, 0, 8'h02, XIdle));
    foreach (q[i]) begin
      drive(q[i]);
      n_total++;
      if (obs() !== q[i].exp) $display("FAIL halt[%0d]: got %h expected %h", i, obs(), q[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_reserved();
    vec_t q[$];
    q.push_back(mk(0, 1, 0, 0, 8'h0C, XIdle));
    q.push_back(mk(0, 1, 1, 0, 8'h0C, XFAck));
    q.push_back(mk(0, 1, 0, 0, 8'h0C, XBusy));
`ifdef CTRL_TRAP_EN
    q.push_back(mk(0, 1, 1, 0, 8'h0C, XTrap));
    q.push_back(mk(0, 0, 0, 0, 8'h0C, XTrap));
    q.push_back(mk(1, 0, 0, 0, 8'h0C, XTrap));
    q.push_back(mk(0, 0, 0, 0, 8'h0C, XIdle));
`else
    q.push_back(mk(0, 1, 0, 0, 8'h0C, XBusy));
    q.push_back(mk(0, 0, 0, 0, 8'h00, XWait));
    q.push_back(mk(0, 0, 1, 0, 8'h00, XFAck));
    q.push_back(mk(0, 0, 0, 0, 8'h00, XBusy));
    q.push_back(mk(0, 0, 0, 0, 8'h00, XBusy));
    q.push_back(mk(0, 0, 0, 0, 8'h00, XIdle));
`endif
    foreach (q[i]) begin
      drive(q[i]);
      n_total++;
      if (obs() !== q[i].exp) $display("FAIL reserved[%0d]: got %h expected %h", i, obs(), q[i].exp);
      else n_pass++;
    end
  endtask

  initial begin
    bus.run       = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.zero_flag = 1'b0;
    bus.opcode    = 4'h0;
    bus.imed_reg  = 4'h0;
    test_reset();
    test_ldi();
    test_add_wait();
    test_jz();
    test_st_ld();
    test_back_to_back();
    test_halt();
    test_reserved();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
